ieu_exres_stage: RTL
====================

# ieu_exres_stage

Execute-to-Memory result stage of the integer execution unit. It captures each ALU output (`ALUResult`, address `Sum`) along with the destination register and memory/writeback control bits. It hands these to the Memory stage through a valid/ready handshake backed by a 2-entry skid buffer, so Memory-stage backpressure never forms a combinational path back into Execute. It also supports pipeline flush and keeps a saturating backpressure-cycle counter for performance monitoring.

## Interface
- `WIDTH`, default `XLEN` (64): datapath width of the result and address.
- `RDW`, default 5: destination register index width.
- `CNTW`, default 16: stall counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `FlushM` in 1: synchronous flush; discards all buffered entries.
- `ValidE` in 1: Execute presents a valid entry.
- `ReadyE` out 1: stage can accept an entry this cycle.
- `ALUResultE` in `WIDTH`: ALU result.
- `SumE` in `WIDTH`: adder output, used as the memory address.
- `RdE` in `RDW`: destination register.
- `RegWriteE` in 1: writeback enable.
- `MemRWE` in 2: memory operation; 10 = read, 01 = write, 00 = none.
- `ValidM` out 1: head entry valid.
- `ReadyM` in 1: Memory consumes the head entry this cycle.
- `ResultM` out `WIDTH`: head ALU result.
- `AddrM` out `WIDTH`: head address.
- `RdM` out `RDW`: head destination register.
- `RegWriteM` out 1: head writeback enable, gated by `ValidM`.
- `MemRWM` out 2: head memory operation, gated by `ValidM`.
- `StallCntM` out `CNTW`: saturating count of cycles with `ValidE & ~ReadyE`.

## Operation
- Storage: a main register (head, drives the M outputs) and a skid register. Occupancy state is EMPTY, ONE or FULL (2-bit encoded).
- Derived signals: `accept = ValidE & ReadyE`, `pop = ValidM & ReadyM`.
- `ValidM = (state != EMPTY)`.
- `ReadyE = (state != FULL)`. It depends on state only; there is no combinational path from `ReadyM`.
- Transitions, evaluated only when `FlushM` and `reset` are low:
  - EMPTY: `accept` → ONE, main loads the input.
  - ONE, `accept & pop` → ONE: main loads the input.
  - ONE, `accept & ~pop` → FULL: skid loads the input and main holds.
  - ONE, `~accept & pop` → EMPTY.
  - ONE, neither → ONE, main holds.
  - FULL, `pop` → ONE: main loads skid. `accept` is impossible here because `ReadyE` = 0.
  - FULL, `~pop` → FULL, both registers hold.
- Ordering: entries leave in strict acceptance order. The skid entry is never bypassed.
- Flush: `FlushM` high → state becomes EMPTY next cycle. An entry accepted in the same cycle is dropped. A `pop` in the same cycle still counts as consumed by Memory. Data registers hold their values; only validity clears.
- Gating: `RegWriteM = mainRegWrite & ValidM` and `MemRWM = mainMemRW & {2{ValidM}}`. `ResultM`, `AddrM` and `RdM` show the main register contents regardless of `ValidM`.
- Stall counter:
  - Increments by 1 in each cycle with `ValidE & ~ReadyE`.
  - Saturates at 2^CNTW−1.
  - Cleared only by `reset`; unaffected by `FlushM`.
- No width conversion: data passes through bit-exact. W64 sign extension is already applied upstream.

## Timing
- Reset values: state EMPTY; main and skid registers all zero.
  - During and after reset: `ValidM` = 0, `ResultM` = `AddrM` = 0, `RdM` = 0, `RegWriteM` = 0, `MemRWM` = 00, `StallCntM` = 0.
  - `ReadyE` = 1 from the first cycle after reset. Inputs presented while `reset` is high are ignored.
- Latency: 1 cycle. An entry accepted at edge N is visible on the M outputs after edge N and can be popped in cycle N+1.
- Throughput: 1 entry/cycle with `ReadyM` held high.
- Backpressure: `ReadyM` low for k ≥ 2 consecutive cycles with continuous `ValidE` → `ReadyE` drops one cycle after the skid fills.
- Recovery: after `ReadyM` returns high, `ReadyE` returns high the following cycle.
- Reset mid-operation: `reset` has priority over `FlushM` and the handshake; all state clears on that edge.
- Simultaneous `FlushM` and `ReadyM` in FULL → EMPTY; the skid entry is lost by design.

## Test plan
- Reset, then `ValidE` = 1, `ALUResultE` = 0x5, `SumE` = 0x1000, `RdE` = 3, `RegWriteE` = 1, `ReadyM` = 1 → the next cycle shows `ValidM` = 1, `ResultM` = 0x5, `AddrM` = 0x1000, `RdM` = 3, `RegWriteM` = 1; the cycle after shows `ValidM` = 0 and `RegWriteM` = 0.
- Stream 8 entries with values 1..8 and `ReadyM` = 1 throughout → 8 consecutive cycles of `ValidM` with `ResultM` = 1..8, `ReadyE` never low, `StallCntM` = 0.
- Hold `ReadyM` = 0 while driving entries A = 0xA, B = 0xB, C = 0xC continuously → `ReadyE` drops after B is accepted, C is held upstream, `StallCntM` increments each blocked cycle. Then raise `ReadyM` → outputs A, B, C in order with no loss or duplication.
- With FULL holding A and B, assert `FlushM` for 1 cycle with `ValidE` = 1 (data 0xD) → the next cycle shows `ValidM` = 0, `RegWriteM` = 0, `MemRWM` = 00 and `ReadyE` = 1; entry D is never output.
- Hold `ReadyM` = 0 with `ValidE` = 1 for 2^CNTW+5 cycles → `StallCntM` saturates at 0xFFFF (CNTW = 16) and does not wrap. Then pulse `FlushM` → the count is unchanged.
- Assert `reset` while in FULL with `StallCntM` = 7 → the next cycle shows all outputs at reset values and `StallCntM` = 0.

Source files
------------

// File: rtl/ieu_exres_stage.sv
// ieu_exres_stage
// Execute-to-Memory result register of the integer execution unit.
// Captures the ALU result, address, destination register and memory /
// writeback control for each Execute entry and hands them to Memory through
// a valid/ready handshake. A 2-entry skid buffer (main + skid) decouples the
// two sides, so ReadyE is a pure function of registered state and never
// depends combinationally on ReadyM.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   FlushM                - drop all buffered entries (data regs hold)
//   ValidE / ReadyE       - Execute-side handshake
//   ALUResultE, SumE, RdE, RegWriteE, MemRWE - entry payload from Execute
//   ValidM / ReadyM       - Memory-side handshake
//   ResultM, AddrM, RdM   - head entry payload (ungated)
//   RegWriteM, MemRWM     - head control bits, gated by ValidM
//   StallCntM             - saturating count of cycles with ValidE & ~ReadyE
module ieu_exres_stage #(
  parameter int XLEN  = 64,
  parameter int WIDTH = XLEN,
  parameter int RDW   = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FlushM,
  input  logic             ValidE,
  output logic             ReadyE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] SumE,
  input  logic [RDW-1:0]   RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       MemRWE,
  output logic             ValidM,
  input  logic             ReadyM,
  output logic [WIDTH-1:0] ResultM,
  output logic [WIDTH-1:0] AddrM,
  output logic [RDW-1:0]   RdM,
  output logic             RegWriteM,
  output logic [1:0]       MemRWM,
  output logic [CNTW-1:0]  StallCntM
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] addr;
    logic [RDW-1:0]   rd;
    logic             reg_write;
    logic [1:0]       mem_rw;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  entry_t          in_entry;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            accept;
  logic            pop;

  assign in_entry = {ALUResultE, SumE, RdE, RegWriteE, MemRWE};

  // Handshake readiness comes straight from the occupancy register.
  assign ReadyE = (state_q != FULL);
  assign ValidM = (state_q != EMPTY);
  assign accept = ValidE & ReadyE;
  assign pop    = ValidM & ReadyM;

  assign ResultM   = main_q.result;
  assign AddrM     = main_q.addr;
  assign RdM       = main_q.rd;
  assign RegWriteM = main_q.reg_write & ValidM;
  assign MemRWM    = main_q.mem_rw & {2{ValidM}};
  assign StallCntM = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FlushM) begin
      // Only validity is cleared; payload registers keep their contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            // Head is stuck: park the new entry behind it.
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ReadyE is low here, so no accept can coincide with the pop.
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ValidE && !ReadyE && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
